// File: rtl/neo_zmc2_pipe_if.sv
// Load/step/pixel bundle of the sprite serializer; the producer side (C-ROM mux) uses master,
// the serializer itself uses slave.
interface neo_zmc2_pipe_if #(
  parameter int BPP = 4,
  parameter int PIX = 8
);
  logic                 CLK_EN;
  logic                 LOAD;
  logic [BPP*PIX-1:0]   CR;
  logic                 H;
  logic                 EVEN;
  logic                 CLR_ERR;
  logic [BPP-1:0]       GAD;
  logic [BPP-1:0]       GBD;
  logic                 DOTA;
  logic                 DOTB;
  logic                 SHADOW_FREE;
  logic                 UNDERRUN;
  logic                 OVERRUN;

  modport master (
    output CLK_EN, LOAD, CR, H, EVEN, CLR_ERR,
    input  GAD, GBD, DOTA, DOTB, SHADOW_FREE, UNDERRUN, OVERRUN
  );

  modport slave (
    input  CLK_EN, LOAD, CR, H, EVEN, CLR_ERR,
    output GAD, GBD, DOTA, DOTB, SHADOW_FREE, UNDERRUN, OVERRUN
  );
endinterface

// File: rtl/neo_zmc2_pipe.sv
// Sprite pixel-pair serializer with shadow/active double buffer; pair 0 visible two cycles after LOAD.
// No backpressure: an early LOAD overwrites the shadow (OVERRUN), a starved step emits 0 (UNDERRUN).
module neo_zmc2_pipe #(
  parameter int BPP    = 4,
  parameter int PIX    = 8,
  parameter bit PLANAR = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  neo_zmc2_pipe_if.slave   bus
);

  localparam int NP = PIX / 2;
  localparam int CW = (NP > 1) ? $clog2(NP) : 1;
  localparam int IW = $clog2(PIX);
  localparam int WW = BPP * PIX;

  typedef logic [BPP-1:0] pix_t;

  logic [WW-1:0] sh_cr;
  logic          sh_h;
  logic          sh_full;
  pix_t          sh_pix [PIX];

  pix_t          act_pix [PIX];
  logic          act_h;
  logic          act_on;
  logic [CW-1:0] cnt;
  logic          armed;

  pix_t          gad_q, gbd_q;
  logic          dota_q, dotb_q;
  logic          underrun_q, overrun_q;

  logic          adv, xfer, starve;
  logic [CW-1:0] pair_k;
  logic          src_h;
  logic [IW-1:0] two_k, idx_f, idx_s;
  pix_t          pix_f, pix_s, lane_a, lane_b;

  // Unpacking happens on the shadow so a transfer copies ready-made pixels.
  always_comb begin
    for (int i = 0; i < PIX; i++) begin
      for (int p = 0; p < BPP; p++) begin
        if (PLANAR)
          sh_pix[i][p] = sh_cr[p*PIX + i];
        else
          sh_pix[i][p] = sh_cr[i*BPP + p];
      end
    end
  end

  assign adv    = act_on && (cnt < CW'(NP - 1));
  assign xfer   = !adv && sh_full;
  assign starve = !adv && !sh_full;

  always_comb begin
    pair_k = '0;
    src_h  = sh_h;
    if (adv) begin
      pair_k = cnt + CW'(1);
      src_h  = act_h;
    end
  end

  // Flipped words walk from the right edge of the tile back to the left.
  always_comb begin
    two_k = IW'({pair_k, 1'b0});
    idx_f = two_k;
    idx_s = two_k + IW'(1);
    if (src_h) begin
      idx_f = IW'(PIX - 1) - two_k;
      idx_s = IW'(PIX - 2) - two_k;
    end
  end

  always_comb begin
    pix_f = sh_pix[idx_f];
    pix_s = sh_pix[idx_s];
    if (adv) begin
      pix_f = act_pix[idx_f];
      pix_s = act_pix[idx_s];
    end
    lane_a = bus.EVEN ? pix_s : pix_f;
    lane_b = bus.EVEN ? pix_f : pix_s;
  end

  // A LOAD coinciding with a transfer refills the shadow the transfer just vacated.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_cr      <= '0;
      sh_h       <= 1'b0;
      sh_full    <= 1'b0;
      armed      <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= bus.LOAD && sh_full && !(bus.CLK_EN && xfer);

      if (bus.LOAD) begin
        sh_cr   <= bus.CR;
        sh_h    <= bus.H;
        sh_full <= 1'b1;
      end else if (bus.CLK_EN && xfer) begin
        sh_full <= 1'b0;
      end

      if (bus.LOAD)
        armed <= 1'b1;
      else if (bus.CLR_ERR)
        armed <= 1'b0;

      if (bus.CLK_EN && starve && armed)
        underrun_q <= 1'b1;
      else if (bus.CLR_ERR)
        underrun_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < PIX; i++) act_pix[i] <= '0;
      act_h  <= 1'b0;
      act_on <= 1'b0;
      cnt    <= '0;
      gad_q  <= '0;
      gbd_q  <= '0;
      dota_q <= 1'b0;
      dotb_q <= 1'b0;
    end else if (bus.CLK_EN) begin
      if (adv) begin
        cnt <= cnt + CW'(1);
      end else if (xfer) begin
        act_pix <= sh_pix;
        act_h   <= sh_h;
        cnt     <= '0;
        act_on  <= 1'b1;
      end else begin
        act_on  <= 1'b0;
      end

      if (starve) begin
        gad_q  <= '0;
        gbd_q  <= '0;
        dota_q <= 1'b0;
        dotb_q <= 1'b0;
      end else begin
        gad_q  <= lane_a;
        gbd_q  <= lane_b;
        dota_q <= |lane_a;
        dotb_q <= |lane_b;
      end
    end
  end

  assign bus.GAD         = gad_q;
  assign bus.GBD         = gbd_q;
  assign bus.DOTA        = dota_q;
  assign bus.DOTB        = dotb_q;
  assign bus.SHADOW_FREE = !sh_full;
  assign bus.UNDERRUN    = underrun_q;
  assign bus.OVERRUN     = overrun_q;

endmodule

// File: tb/tb_neo_zmc2_pipe.sv
// Directed bench for the sprite serializer: planar 4bpp x8 instance and packed 8bpp x4 instance.
module tb_neo_zmc2_pipe;

  logic CLK;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;

  neo_zmc2_pipe_if #(.BPP(4), .PIX(8)) b1 ();
  neo_zmc2_pipe_if #(.BPP(8), .PIX(4)) b2 ();

  neo_zmc2_pipe #(.BPP(4), .PIX(8), .PLANAR(1'b1)) dut1 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b1)
  );

  neo_zmc2_pipe #(.BPP(8), .PIX(4), .PLANAR(1'b0)) dut2 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (b2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load1(input logic [31:0] cr, input logic h);
    b1.LOAD = 1'b1; b1.CR = cr; b1.H = h;
    tick();
    b1.LOAD = 1'b0;
  endtask

  task automatic step1(input logic even);
    b1.CLK_EN = 1'b1; b1.EVEN = even;
    tick();
    b1.CLK_EN = 1'b0; b1.EVEN = 1'b0;
  endtask

  task automatic load2(input logic [31:0] cr);
    b2.LOAD = 1'b1; b2.CR = cr; b2.H = 1'b0;
    tick();
    b2.LOAD = 1'b0;
  endtask

  task automatic step2();
    b2.CLK_EN = 1'b1;
    tick();
    b2.CLK_EN = 1'b0;
  endtask

  task automatic check_pair1(input string tag, input int a, input int b);
    check({tag, "_gad"},  32'(b1.GAD),  32'(a));
    check({tag, "_gbd"},  32'(b1.GBD),  32'(b));
    check({tag, "_dota"}, 32'(b1.DOTA), 32'(a != 0));
    check({tag, "_dotb"}, 32'(b1.DOTB), 32'(b != 0));
  endtask

  localparam logic [31:0] W_A  = 32'h00F0CCAA;  // planar: pixel i = i
  localparam logic [31:0] W_B  = 32'hFFF0CCAA;  // planar: pixel i = i + 8

  initial begin
    RESET = 1'b1;
    b1.CLK_EN = 0; b1.LOAD = 0; b1.CR = '0; b1.H = 0; b1.EVEN = 0; b1.CLR_ERR = 0;
    b2.CLK_EN = 0; b2.LOAD = 0; b2.CR = '0; b2.H = 0; b2.EVEN = 0; b2.CLR_ERR = 0;
    tick();
    tick();
    check("rst_gad",  32'(b1.GAD), 0);
    check("rst_gbd",  32'(b1.GBD), 0);
    check("rst_dota", 32'(b1.DOTA), 0);
    check("rst_dotb", 32'(b1.DOTB), 0);
    check("rst_sfree", 32'(b1.SHADOW_FREE), 1);
    check("rst_under", 32'(b1.UNDERRUN), 0);
    check("rst_over",  32'(b1.OVERRUN), 0);
    RESET = 1'b0;
    tick();

    // plain word, no flip, no swap
    load1(W_A, 1'b0);
    check("t1_sfree_after_load", 32'(b1.SHADOW_FREE), 0);
    for (int k = 0; k < 4; k++) begin
      step1(1'b0);
      check_pair1($sformatf("t1_p%0d", k), 2*k, 2*k + 1);
    end
    check("t1_sfree_after_xfer", 32'(b1.SHADOW_FREE), 1);

    // flipped word, lane swap on steps 2-3
    load1(W_A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic ev;
      ev = (k == 1 || k == 2);
      step1(ev);
      if (ev) check_pair1($sformatf("t2_p%0d", k), 6 - 2*k, 7 - 2*k);
      else    check_pair1($sformatf("t2_p%0d", k), 7 - 2*k, 6 - 2*k);
    end

    // back-to-back words, second LOAD together with step 2
    load1(W_A, 1'b0);
    for (int i = 0; i < 8; i++) begin
      b1.CLK_EN = 1'b1;
      if (i == 1) begin
        b1.LOAD = 1'b1; b1.CR = W_B; b1.H = 1'b0;
      end
      tick();
      b1.LOAD = 1'b0;
      check_pair1($sformatf("t3_s%0d", i), 2*i, 2*i + 1);
      check($sformatf("t3_over_s%0d", i), 32'(b1.OVERRUN), 0);
    end
    b1.CLK_EN = 1'b0;

    // two LOADs with no step between: second word wins
    load1(W_B, 1'b0);
    check("t4_over_first", 32'(b1.OVERRUN), 0);
    load1(W_A, 1'b1);
    check("t4_over_pulse", 32'(b1.OVERRUN), 1);
    check("t4_sfree_hold", 32'(b1.SHADOW_FREE), 0);
    tick();
    check("t4_over_drop", 32'(b1.OVERRUN), 0);
    check("t4_sfree_wait", 32'(b1.SHADOW_FREE), 0);
    step1(1'b0);
    check_pair1("t4_p0", 7, 6);
    check("t4_sfree_rise", 32'(b1.SHADOW_FREE), 1);
    for (int k = 1; k < 4; k++) begin
      step1(1'b0);
      check_pair1($sformatf("t4_p%0d", k), 7 - 2*k, 6 - 2*k);
    end

    // underrun after the word runs dry, then clear
    load1(W_A, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step1(1'b0);
      check($sformatf("t5_under_p%0d", k), 32'(b1.UNDERRUN), 0);
    end
    step1(1'b0);
    check_pair1("t5_dry", 0, 0);
    check("t5_under_set", 32'(b1.UNDERRUN), 1);
    tick();
    check("t5_under_hold", 32'(b1.UNDERRUN), 1);
    b1.CLR_ERR = 1'b1;
    tick();
    b1.CLR_ERR = 1'b0;
    check("t5_under_clr", 32'(b1.UNDERRUN), 0);
    step1(1'b0);
    check("t5_under_stay", 32'(b1.UNDERRUN), 0);
    check_pair1("t5_dry2", 0, 0);

    // packed 8bpp x4 instance
    load2(32'h44332211);
    step2();
    check("t6_gad0", 32'(b2.GAD), 32'h11);
    check("t6_gbd0", 32'(b2.GBD), 32'h22);
    check("t6_dota0", 32'(b2.DOTA), 1);
    step2();
    check("t6_gad1", 32'(b2.GAD), 32'h33);
    check("t6_gbd1", 32'(b2.GBD), 32'h44);
    load2(32'h44332211);
    step2();
    check("t6_mid_gad", 32'(b2.GAD), 32'h11);
    load2(32'h88776655);
    check("t6_sfree_full", 32'(b2.SHADOW_FREE), 0);

    // asynchronous reset mid-word, sampled between clock edges
    #2;
    RESET = 1'b1;
    #1;
    check("t7_rst_gad",   32'(b2.GAD), 0);
    check("t7_rst_gbd",   32'(b2.GBD), 0);
    check("t7_rst_dota",  32'(b2.DOTA), 0);
    check("t7_rst_sfree", 32'(b2.SHADOW_FREE), 1);
    tick();
    RESET = 1'b0;
    step2();
    check("t7_post_gad",   32'(b2.GAD), 0);
    check("t7_post_gbd",   32'(b2.GBD), 0);
    check("t7_post_under", 32'(b2.UNDERRUN), 0);
    check("t7_post_sfree", 32'(b2.SHADOW_FREE), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
